fwd_ctrl: RTL and testbench

- Forwarding and hazard control for the 5-stage pipeline.
- Tracks the destination register of every in-flight instruction in EX, MEM and WB.
- Compares them against the source registers of the instruction in ID.
- Produces registered 2-bit select codes, valid in EX, that drive the two 16-bit operand forwarding muxes (4:1, sel 00/01/10/11 → input 1/2/3/4).
- Detects load-use hazards and stalls ID for one cycle.

---
 rtl/fwd_ctrl.sv | 74 +++++++
 tb/tb_fwd_ctrl.sv | 89 ++++++++
 2 files changed

// File: rtl/fwd_ctrl.sv
// fwd_ctrl: EX/MEM/WB forwarding selects and load-use stall for the 5-stage pipeline
// FWD_WB_BYPASS_EN enables the write-back bypass (code 11) for a read-before-write register file.
module fwd_ctrl #(
  parameter int REG_AW = 3,
  parameter int ZERO_REG = 1,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic              flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wr_en;
    logic              is_load;
  } rec_t;
  function automatic logic qual(rec_t r, logic [REG_AW-1:0] rs, logic used);
    return r.valid & r.wr_en & used & (r.rd == rs) & ((ZERO_REG == 0) | (r.rd != '0));
  endfunction
  rec_t ex_rec, mem_rec, id_rec;
  logic ea, eb, ma, mb, wa, wb, capture;
  logic [1:0] sel_a, sel_b;
  assign id_rec = '{valid: 1'b1, rd: id_rd, wr_en: id_wr_en, is_load: id_is_load};
  assign ea = qual(ex_rec, id_rs1, id_rs1_used);
  assign eb = qual(ex_rec, id_rs2, id_rs2_used);
  assign ma = qual(mem_rec, id_rs1, id_rs1_used);
  assign mb = qual(mem_rec, id_rs2, id_rs2_used);
`ifdef FWD_WB_BYPASS_EN
  rec_t wb_rec;
  assign wa = qual(wb_rec, id_rs1, id_rs1_used);
  assign wb = qual(wb_rec, id_rs2, id_rs2_used);
  always_ff @(posedge clk)
    if (rst) wb_rec <= '0;
    else wb_rec <= mem_rec;
`else
  // Write-first register file already returns the WB value, so WB never forwards.
  assign wa = 1'b0;
  assign wb = 1'b0;
`endif
  always_comb begin
    sel_a = ea ? 2'b01 : ma ? 2'b10 : wa ? 2'b11 : 2'b00;
    sel_b = eb ? 2'b01 : mb ? 2'b10 : wb ? 2'b11 : 2'b00;
    stall = id_valid & ex_rec.is_load & (ea | eb) & ~flush;
    capture = id_valid & ~stall & ~flush;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rec <= '0;
      mem_rec <= '0;
      fwd_a_sel <= 2'b00;
      fwd_b_sel <= 2'b00;
      stall_cnt <= '0;
    end else begin
      mem_rec <= ex_rec;
      ex_rec <= capture ? id_rec : '0;
      fwd_a_sel <= capture ? sel_a : 2'b00;
      fwd_b_sel <= capture ? sel_b : 2'b00;
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_fwd_ctrl.sv
// tb_fwd_ctrl: directed vectors for fwd_ctrl with hand-computed selects, stall and stall count.
module tb_fwd_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic id_valid, id_rs1_used, id_rs2_used, id_wr_en, id_is_load, flush;
  logic [2:0] id_rs1, id_rs2, id_rd;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic stall;
  logic [15:0] stall_cnt;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  fwd_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .stall_cnt(stall_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Drive one ID slot, check stall in-cycle, then the selects once it reaches EX.
  task automatic issue(input string tag, input logic v, input logic [2:0] rs1, input logic u1,
                       input logic [2:0] rs2, input logic u2, input logic [2:0] rd,
                       input logic we, input logic ld, input logic fl,
                       input logic exp_stall, input logic [1:0] exp_a, input logic [1:0] exp_b);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_wr_en = we; id_is_load = ld; flush = fl;
    #1;
    chk({tag, ".stall"}, 32'(stall), 32'(exp_stall));
    @(posedge clk); #1;
    chk({tag, ".a"}, 32'(fwd_a_sel), 32'(exp_a));
    chk({tag, ".b"}, 32'(fwd_b_sel), 32'(exp_b));
  endtask
  initial begin
    id_valid = 1; id_rs1 = 3; id_rs2 = 3; id_rs1_used = 1; id_rs2_used = 1;
    id_rd = 3; id_wr_en = 1; id_is_load = 1; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.a", 32'(fwd_a_sel), 0);
    chk("rst.b", 32'(fwd_b_sel), 0);
    chk("rst.stall", 32'(stall), 0);
    chk("rst.cnt", 32'(stall_cnt), 0);
    rst = 0;
    //      tag      v rs1 u1 rs2 u2 rd we ld fl  st a  b
    issue("w3",     1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    issue("r3ex",   1, 3, 1, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    issue("w3b",    1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    issue("w7",     1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0);
    issue("r3m7e",  1, 3, 1, 7, 1, 1, 0, 0, 0, 0, 2, 1);
    issue("ld2",    1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0);
    issue("use2",   1, 0, 0, 2, 1, 1, 1, 0, 0, 1, 0, 0);
    chk("cnt1", 32'(stall_cnt), 1);
    issue("use2b",  1, 0, 0, 2, 1, 1, 1, 0, 0, 0, 0, 2);
    chk("cnt1b", 32'(stall_cnt), 1);
    issue("w4a",    1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0);
    issue("w4b",    1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0);
    issue("r4r4",   1, 4, 1, 4, 1, 1, 0, 0, 0, 0, 1, 1);
    issue("w0",     1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    issue("r0",     1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    issue("ld1",    1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    issue("flush",  1, 1, 1, 0, 0, 2, 1, 0, 1, 0, 0, 0);
    chk("cnt_fl", 32'(stall_cnt), 1);
    issue("w5",     1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    issue("nop1",   1, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0);
    issue("w6",     1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0);
`ifdef FWD_WB_BYPASS_EN
    issue("r5wb",   1, 5, 1, 0, 0, 1, 0, 0, 0, 0, 3, 0);
`else
    issue("r5wb",   1, 5, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
`endif
    issue("ld6",    1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0);
    issue("inval",  0, 6, 1, 6, 1, 1, 1, 0, 0, 0, 0, 0);
    issue("ld2b",   1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0);
    issue("use22",  1, 2, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0);
    issue("use22b", 1, 2, 1, 2, 1, 1, 0, 0, 0, 0, 2, 2);
    chk("cnt2", 32'(stall_cnt), 2);
    issue("w3c",    1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    rst = 1; id_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    chk("mrst.cnt", 32'(stall_cnt), 0);
    issue("r3post", 1, 3, 1, 3, 1, 1, 0, 0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
